// File: rtl/pe_sad_acc_if.sv
// Port bundle for the SAD processing element.
// The PE is the slave, and the array controller or previous stage is the master.
interface pe_sad_acc_if #(
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned NUM_CB  = 4,
    parameter int unsigned REF_SRC = 2,
    parameter int unsigned ACC_W   = PIXEL_W + 8
);
    localparam int unsigned CB_W = $clog2(NUM_CB);
    localparam int unsigned RS_W = (REF_SRC > 2) ? $clog2(REF_SRC) : 1;

    logic [PIXEL_W-1:0]         cur_in;
    logic                       cur_load;
    logic [CB_W-1:0]            cur_wsel;
    logic [PIXEL_W-1:0]         cur_out;
    logic                       cur_load_out;
    logic [CB_W-1:0]            cur_wsel_out;
    logic [REF_SRC*PIXEL_W-1:0] ref_in;
    logic [RS_W-1:0]            ref_sel;
    logic                       ref_en;
    logic [PIXEL_W-1:0]         ref_out;
    logic [CB_W-1:0]            abs_sel;
    logic                       acc_en;
    logic                       acc_start;
    logic                       acc_last;
    logic [PIXEL_W-1:0]         ad_out;
    logic [ACC_W-1:0]           sad_out;
    logic                       sad_valid;
    logic                       sad_sat;

    modport master (
        output cur_in, cur_load, cur_wsel, ref_in, ref_sel, ref_en,
               abs_sel, acc_en, acc_start, acc_last,
        input  cur_out, cur_load_out, cur_wsel_out, ref_out, ad_out,
               sad_out, sad_valid, sad_sat
    );

    modport slave (
        input  cur_in, cur_load, cur_wsel, ref_in, ref_sel, ref_en,
               abs_sel, acc_en, acc_start, acc_last,
        output cur_out, cur_load_out, cur_wsel_out, ref_out, ad_out,
               sad_out, sad_valid, sad_sat
    );
endinterface

// File: rtl/pe_sad_acc.sv
// Motion-estimation PE: systolic current-pixel chain, banked current block,
// registered |cur-ref| and a saturating per-candidate SAD accumulator.
module pe_sad_acc #(
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned NUM_CB  = 4,
    parameter int unsigned REF_SRC = 2,
    parameter int unsigned ACC_W   = PIXEL_W + 8
) (
    input logic         clk,
    input logic         rst_n,
    pe_sad_acc_if.slave bus
);
    localparam int unsigned CB_W = $clog2(NUM_CB);
    localparam int unsigned RS_W = (REF_SRC > 2) ? $clog2(REF_SRC) : 1;
    localparam logic [RS_W:0] REF_LIM = (RS_W + 1)'(REF_SRC);

    logic [PIXEL_W-1:0] r_bank [NUM_CB];
    logic [PIXEL_W-1:0] r_ref;
    logic [PIXEL_W-1:0] r_cur;
    logic               r_cur_load;
    logic [CB_W-1:0]    r_cur_wsel;
    logic [PIXEL_W-1:0] r_ad;
    logic               r_v1;
    logic               r_s1;
    logic               r_l1;
    logic [ACC_W-1:0]   r_acc;
    logic               r_sat;
    logic [ACC_W-1:0]   r_sad;
    logic               r_sad_sat;
    logic               r_sad_valid;

    logic [PIXEL_W-1:0] w_ref_src [REF_SRC];
    logic               w_ref_ok;
    logic [PIXEL_W-1:0] w_cur_sel;
    logic [PIXEL_W:0]   w_diff;
    logic [PIXEL_W-1:0] w_abs;
    logic [ACC_W-1:0]   w_base;
    logic [ACC_W:0]     w_sum;
    logic               w_ovf;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_sat_next;

    for (genvar k = 0; k < REF_SRC; k++) begin : g_ref
        assign w_ref_src[k] = bus.ref_in[k*PIXEL_W +: PIXEL_W];
    end

    always_comb begin
        w_ref_ok   = {1'b0, bus.ref_sel} < REF_LIM;
        w_cur_sel  = r_bank[bus.abs_sel];
        w_diff     = {1'b0, w_cur_sel} - {1'b0, r_ref};
        w_abs      = w_diff[PIXEL_W] ? (r_ref - w_cur_sel) : w_diff[PIXEL_W-1:0];
        // A start term discards both the running sum and the sticky flag
        w_base     = r_s1 ? '0 : r_acc;
        w_sum      = {1'b0, w_base} + {{(ACC_W + 1 - PIXEL_W){1'b0}}, r_ad};
        w_ovf      = w_sum[ACC_W];
        w_acc_next = w_ovf ? '1 : w_sum[ACC_W-1:0];
        w_sat_next = w_ovf | (r_sat & ~r_s1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CB; i++) begin
                r_bank[i] <= '0;
            end
            r_ref       <= '0;
            r_cur       <= '0;
            r_cur_load  <= 1'b0;
            r_cur_wsel  <= '0;
            r_ad        <= '0;
            r_v1        <= 1'b0;
            r_s1        <= 1'b0;
            r_l1        <= 1'b0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_sad       <= '0;
            r_sad_sat   <= 1'b0;
            r_sad_valid <= 1'b0;
        end else begin
            r_cur      <= bus.cur_in;
            r_cur_load <= bus.cur_load;
            r_cur_wsel <= bus.cur_wsel;
            if (bus.cur_load) begin
                r_bank[bus.cur_wsel] <= bus.cur_in;
            end
            if (bus.ref_en && w_ref_ok) begin
                r_ref <= w_ref_src[bus.ref_sel];
            end
            r_ad <= w_abs;
            r_v1 <= bus.acc_en;
            r_s1 <= bus.acc_en & bus.acc_start;
            r_l1 <= bus.acc_en & bus.acc_last;
            if (r_v1) begin
                r_acc <= w_acc_next;
                r_sat <= w_sat_next;
            end
            r_sad_valid <= r_v1 & r_l1;
            if (r_v1 & r_l1) begin
                r_sad     <= w_acc_next;
                r_sad_sat <= w_sat_next;
            end
        end
    end

    assign bus.cur_out      = r_cur;
    assign bus.cur_load_out = r_cur_load;
    assign bus.cur_wsel_out = r_cur_wsel;
    assign bus.ref_out      = r_ref;
    assign bus.ad_out       = r_ad;
    assign bus.sad_out      = r_sad;
    assign bus.sad_valid    = r_sad_valid;
    assign bus.sad_sat      = r_sad_sat;
endmodule

// File: tb/tb_pe_sad_acc.sv
// Bench for pe_sad_acc: a default instance (ACC_W=16, REF_SRC=2) and a narrow
// instance (ACC_W=9, REF_SRC=3) share stimulus; directed table plus random vs model.
module tb_pe_sad_acc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cur_in;
    logic        cur_load;
    logic [1:0]  cur_wsel;
    logic [23:0] ref_vec;
    logic [1:0]  ref_sel;
    logic        ref_en;
    logic [1:0]  abs_sel;
    logic        acc_en;
    logic        acc_start;
    logic        acc_last;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_sad_acc_if #(.PIXEL_W(8), .NUM_CB(4), .REF_SRC(2), .ACC_W(16)) ia ();
    pe_sad_acc_if #(.PIXEL_W(8), .NUM_CB(4), .REF_SRC(3), .ACC_W(9))  ib ();

    assign ia.cur_in    = cur_in;    assign ib.cur_in    = cur_in;
    assign ia.cur_load  = cur_load;  assign ib.cur_load  = cur_load;
    assign ia.cur_wsel  = cur_wsel;  assign ib.cur_wsel  = cur_wsel;
    assign ia.ref_in    = ref_vec[15:0];
    assign ib.ref_in    = ref_vec;
    assign ia.ref_sel   = ref_sel[0];
    assign ib.ref_sel   = ref_sel;
    assign ia.ref_en    = ref_en;    assign ib.ref_en    = ref_en;
    assign ia.abs_sel   = abs_sel;   assign ib.abs_sel   = abs_sel;
    assign ia.acc_en    = acc_en;    assign ib.acc_en    = acc_en;
    assign ia.acc_start = acc_start; assign ib.acc_start = acc_start;
    assign ia.acc_last  = acc_last;  assign ib.acc_last  = acc_last;

    pe_sad_acc #(.PIXEL_W(8), .NUM_CB(4), .REF_SRC(2), .ACC_W(16)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );
    pe_sad_acc #(.PIXEL_W(8), .NUM_CB(4), .REF_SRC(3), .ACC_W(9)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    typedef struct {
        logic [1:0] sel;
        logic [7:0] exp_ad;
    } sweep_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cur_load  = 1'b0;
        ref_en    = 1'b0;
        acc_en    = 1'b0;
        acc_start = 1'b0;
        acc_last  = 1'b0;
    endtask

    task automatic load_bank(input logic [1:0] b, input logic [7:0] v);
        cur_load = 1'b1;
        cur_wsel = b;
        cur_in   = v;
    endtask

    task automatic term(input logic [1:0] s, input logic st, input logic ls);
        abs_sel   = s;
        acc_en    = 1'b1;
        acc_start = st;
        acc_last  = ls;
    endtask

    task automatic chk_sad(input string name, input logic v, input logic [31:0] sa,
                           input logic ta, input logic [31:0] sb, input logic tb_sat);
        chk({name, "_valid_a"}, ia.sad_valid, v);
        chk({name, "_valid_b"}, ib.sad_valid, v);
        chk({name, "_sad_a"},   ia.sad_out,   sa);
        chk({name, "_sat_a"},   ia.sad_sat,   ta);
        chk({name, "_sad_b"},   ib.sad_out,   sb);
        chk({name, "_sat_b"},   ib.sad_sat,   tb_sat);
    endtask

    // Random-phase reference model
    logic [7:0]  mbank [4];
    logic [7:0]  mref  [2];
    logic [31:0] tot   [2];
    logic [31:0] esad  [2];
    logic        esat  [2];
    logic [7:0]  c_ad  [2];
    logic [7:0]  p_ad  [2];
    logic [31:0] accmax [2];

    initial begin
        sweep_t vec [4];
        bit in_sad;
        bit p_en, p_start, p_last, e_valid;
        int unsigned s;

        vec[0] = '{2'd0, 8'd15};
        vec[1] = '{2'd1, 8'd5};
        vec[2] = '{2'd2, 8'd5};
        vec[3] = '{2'd3, 8'd15};

        rst_n = 1'b0;
        cur_in = '0; cur_wsel = '0; ref_vec = '0; ref_sel = '0; abs_sel = '0;
        idle();
        step(); step();
        rst_n = 1'b1;
        chk("rst_cur_out",  ia.cur_out, 0);
        chk("rst_load_out", ia.cur_load_out, 0);
        chk("rst_wsel_out", ia.cur_wsel_out, 0);
        chk("rst_ref_out",  ia.ref_out, 0);
        chk("rst_ad_out",   ia.ad_out, 0);
        chk_sad("rst", 1'b0, 0, 1'b0, 0, 1'b0);

        // Banks 10,20,30,40, ref 25 from source 1
        for (int i = 0; i < 4; i++) begin
            load_bank(2'(i), 8'((i + 1) * 10));
            step();
        end
        cur_load = 1'b0;
        ref_vec = {8'd77, 8'd25, 8'd99};
        ref_sel = 2'd1;
        ref_en  = 1'b1;
        step();
        ref_en = 1'b0;
        chk("ref_load_a", ia.ref_out, 25);
        chk("ref_load_b", ib.ref_out, 25);
        for (int i = 0; i < 4; i++) begin
            abs_sel = vec[i].sel;
            step();
            chk("sweep_ad_a", ia.ad_out, vec[i].exp_ad);
            chk("sweep_ad_b", ib.ad_out, vec[i].exp_ad);
        end

        // Out-of-range source on the 3-source instance holds ref_out
        ref_sel = 2'd3;
        ref_en  = 1'b1;
        step();
        ref_en = 1'b0;
        chk("ref_hold_b", ib.ref_out, 25);
        chk("ref_src1_a", ia.ref_out, 25);

        // Chain forwarding plus write to bank 2 (difference sees old value)
        load_bank(2'd2, 8'h5A);
        abs_sel = 2'd2;
        step();
        cur_load = 1'b0;
        chk("chain_cur_out",  ia.cur_out, 8'h5A);
        chk("chain_load_out", ia.cur_load_out, 1);
        chk("chain_wsel_out", ia.cur_wsel_out, 2);
        chk("chain_old_ad",   ia.ad_out, 5);
        step();
        chk("chain_new_ad",   ia.ad_out, 65);
        chk("chain_load_drop", ia.cur_load_out, 0);

        // 4-term SAD 3+7+0+255, then back-to-back single term 9
        ref_vec = '0; ref_sel = 2'd0; ref_en = 1'b1;
        load_bank(2'd0, 8'd3); step();
        ref_en = 1'b0;
        load_bank(2'd1, 8'd7); step();
        load_bank(2'd2, 8'd0); step();
        load_bank(2'd3, 8'd255); step();
        cur_load = 1'b0;
        term(2'd0, 1'b1, 1'b0); step();
        term(2'd1, 1'b0, 1'b0); load_bank(2'd0, 8'd9); step();
        cur_load = 1'b0;
        term(2'd2, 1'b0, 1'b0); step();
        chk("sad4_novalid_a", ia.sad_valid, 0);
        term(2'd3, 1'b0, 1'b1); step();
        chk("sad4_novalid2_a", ia.sad_valid, 0);
        term(2'd0, 1'b1, 1'b1); step();
        chk_sad("sad4", 1'b1, 265, 1'b0, 265, 1'b0);
        idle(); step();
        chk_sad("b2b", 1'b1, 9, 1'b0, 9, 1'b0);
        step();
        chk_sad("b2b_hold", 1'b0, 9, 1'b0, 9, 1'b0);

        // Saturation on the 9-bit instance, then a fresh SAD clears the flag
        term(2'd3, 1'b1, 1'b0); load_bank(2'd1, 8'd1); step();
        cur_load = 1'b0;
        term(2'd3, 1'b0, 1'b0); step();
        term(2'd3, 1'b0, 1'b1); step();
        term(2'd1, 1'b1, 1'b0); step();
        chk_sad("sat", 1'b1, 765, 1'b0, 511, 1'b1);
        term(2'd1, 1'b0, 1'b1); step();
        chk("sat_pulse_a", ia.sad_valid, 0);
        idle(); step();
        chk_sad("unsat", 1'b1, 2, 1'b0, 2, 1'b0);

        // Same-cycle bank write and ref load: difference uses old values
        load_bank(2'd1, 8'd50); step();
        load_bank(2'd1, 8'd60); abs_sel = 2'd1; step();
        chk("rw_old_bank", ia.ad_out, 50);
        cur_load = 1'b0;
        ref_vec = {8'd30, 8'd30, 8'd30}; ref_en = 1'b1; step();
        chk("rw_new_bank", ia.ad_out, 60);
        ref_en = 1'b0; step();
        chk("rw_new_ref", ia.ad_out, 30);

        // Reset between start and last: nothing completes
        term(2'd1, 1'b1, 1'b0); step();
        term(2'd1, 1'b0, 1'b1); step();
        idle();
        rst_n = 1'b0;
        #1;
        chk("midrst_ref",  ia.ref_out, 0);
        chk("midrst_ad",   ia.ad_out, 0);
        chk("midrst_cur",  ia.cur_out, 0);
        chk_sad("midrst", 1'b0, 0, 1'b0, 0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk("midrst_novalid1", ia.sad_valid, 0);
        load_bank(2'd0, 8'd12); step();
        chk("midrst_novalid2", ia.sad_valid, 0);
        load_bank(2'd1, 8'd5); term(2'd0, 1'b1, 1'b0); step();
        cur_load = 1'b0;
        term(2'd1, 1'b0, 1'b1); step();
        idle(); step();
        chk_sad("post_rst", 1'b1, 17, 1'b0, 17, 1'b0);

        // Randomised run against the model
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mbank[i] = '0;
        for (int d = 0; d < 2; d++) begin
            mref[d] = '0; tot[d] = 0; esad[d] = 0; esat[d] = 1'b0; p_ad[d] = '0;
        end
        accmax[0] = 65535;
        accmax[1] = 511;
        in_sad = 1'b0;
        p_en = 1'b0; p_start = 1'b0; p_last = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            cur_in   = 8'($urandom);
            cur_load = 1'($urandom_range(0, 1));
            cur_wsel = 2'($urandom);
            ref_vec  = 24'($urandom);
            ref_sel  = 2'($urandom);
            ref_en   = ($urandom_range(0, 3) == 0);
            abs_sel  = 2'($urandom);
            acc_en   = ($urandom_range(0, 3) != 0);
            acc_last = ($urandom_range(0, 3) == 0);
            if (acc_en) acc_start = !in_sad || ($urandom_range(0, 7) == 0);
            else        acc_start = 1'($urandom_range(0, 1));
            if (acc_en) in_sad = !acc_last;

            for (int d = 0; d < 2; d++) begin
                int dv;
                dv = int'(mbank[abs_sel]) - int'(mref[d]);
                c_ad[d] = 8'(dv < 0 ? -dv : dv);
            end
            if (cur_load) mbank[cur_wsel] = cur_in;
            if (ref_en) begin
                s = ref_sel[0];
                mref[0] = ref_vec[s*8 +: 8];
                if (ref_sel < 3) begin
                    s = ref_sel;
                    mref[1] = ref_vec[s*8 +: 8];
                end
            end

            step();

            e_valid = p_en && p_last;
            for (int d = 0; d < 2; d++) begin
                if (p_en) tot[d] = (p_start ? 0 : tot[d]) + p_ad[d];
                if (e_valid) begin
                    esad[d] = (tot[d] > accmax[d]) ? accmax[d] : tot[d];
                    esat[d] = (tot[d] > accmax[d]);
                end
            end
            chk("rnd_ad_a",    ia.ad_out, c_ad[0]);
            chk("rnd_ad_b",    ib.ad_out, c_ad[1]);
            chk("rnd_ref_a",   ia.ref_out, mref[0]);
            chk("rnd_ref_b",   ib.ref_out, mref[1]);
            chk("rnd_cur_out", ia.cur_out, cur_in);
            chk("rnd_wsel_out", ib.cur_wsel_out, cur_wsel);
            chk_sad("rnd", e_valid, esad[0], esat[0], esad[1], esat[1]);

            p_en = acc_en; p_start = acc_start; p_last = acc_last;
            p_ad[0] = c_ad[0]; p_ad[1] = c_ad[1];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
